// File: rtl/sata_gen_negotiator_pkg.sv
// sata_gen_negotiator_pkg: shared types and constants for the SATA
// link-speed negotiator (state enum, generation codes, stat width).
package sata_gen_negotiator_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_OOB,
    S_LINK_WAIT,
    S_UP,
    S_FAIL
  } state_t;

  localparam logic [1:0] SATA_GEN1 = 2'd1;
  localparam logic [1:0] SATA_GEN2 = 2'd2;
  localparam logic [1:0] SATA_GEN3 = 2'd3;

  localparam int STAT_W = 8;

  // Generation 0 is not a real speed; treat it as Gen1.
  function automatic logic [1:0] clamp_gen(
    input logic [1:0] g
  );
    return (g == 2'd0) ? SATA_GEN1 : g;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sata_gen_negotiator_sync.sv
// sata_gen_negotiator_sync: 2-flop level synchronizer, sync reset to 0.
// Ports: clk, reset (sync, active-high), d (async level), q (synced level).
module sata_gen_negotiator_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sata_gen_negotiator.sv
// sata_gen_negotiator: SATA link-speed negotiation, Gen3->Gen2->Gen1.
// Macro SATA_GEN_NEGOTIATOR_STAT_EN enables link_loss_cnt/attempt_cnt.
// Ports: clk, reset (sync, active-high); start/max_gen begin a run;
// recfg_request/recfg_sata_gen/recfg_ready talk to the reconfigurator;
// oob_start restarts OOB; link_up is the async PHY link level;
// busy/done/fail/cur_gen report status; *_cnt are saturating stats.
module sata_gen_negotiator
  import sata_gen_negotiator_pkg::*;
#(
  parameter int TIMEOUT = 65536,
  parameter int RETRIES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        max_gen,
  input  logic              link_up,
  output logic              recfg_request,
  output logic [1:0]        recfg_sata_gen,
  input  logic              recfg_ready,
  output logic              oob_start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [1:0]        cur_gen,
  output logic [STAT_W-1:0] link_loss_cnt,
  output logic [STAT_W-1:0] attempt_cnt
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = (RETRIES > 1) ? $clog2(RETRIES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [1:0]    gen_max_q, gen_max_d;
  logic [1:0]    cur_gen_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          link_s;
  logic          start_acc;
  logic          retry_more;

  sata_gen_negotiator_sync u_link_sync (
    .clk   (clk),
    .reset (reset),
    .d     (link_up),
    .q     (link_s)
  );

  assign retry_more = (int'(retry_q) + 1) < RETRIES;

  always_comb begin
    state_d   = state_q;
    gen_max_d = gen_max_q;
    cur_gen_d = cur_gen;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    start_acc = 1'b0;

    unique case (state_q)
      S_IDLE, S_FAIL: begin
        if (start) start_acc = 1'b1;
      end
      S_REQ: begin
        if (recfg_request && recfg_ready)
          state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!recfg_ready) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (recfg_ready) state_d = S_OOB;
      end
      S_OOB: begin
        tmo_d   = '0;
        state_d = S_LINK_WAIT;
      end
      S_LINK_WAIT: begin
        // Link has priority over a coincident timeout.
        if (link_s) begin
          state_d = S_UP;
        end else if (tmo_q != TMO_LAST) begin
          tmo_d = tmo_q + 1'b1;
        end else if (retry_more) begin
          retry_d = retry_q + 1'b1;
          state_d = S_OOB;
        end else if (cur_gen > SATA_GEN1) begin
          cur_gen_d = cur_gen - 2'd1;
          retry_d   = '0;
          state_d   = S_REQ;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_UP: begin
        if (start) begin
          start_acc = 1'b1;
        end else if (!link_s) begin
          cur_gen_d = gen_max_q;
          retry_d   = '0;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_acc) begin
      gen_max_d = clamp_gen(max_gen);
      cur_gen_d = clamp_gen(max_gen);
      retry_d   = '0;
      state_d   = S_REQ;
    end
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      gen_max_q      <= '0;
      cur_gen        <= '0;
      retry_q        <= '0;
      tmo_q          <= '0;
      recfg_request  <= 1'b0;
      recfg_sata_gen <= '0;
      oob_start      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fail           <= 1'b0;
    end else begin
      state_q       <= state_d;
      gen_max_q     <= gen_max_d;
      cur_gen       <= cur_gen_d;
      retry_q       <= retry_d;
      tmo_q         <= tmo_d;
      recfg_request <= (state_d == S_REQ);
      if (state_d == S_REQ)
        recfg_sata_gen <= cur_gen_d;
      oob_start <= (state_d == S_OOB);
      busy      <= state_d inside {S_REQ, S_WAIT_ACK,
                                   S_WAIT_DONE, S_OOB,
                                   S_LINK_WAIT};
      done      <= (state_d == S_UP);
      fail      <= (state_d == S_FAIL);
    end
  end

`ifdef SATA_GEN_NEGOTIATOR_STAT_EN
  logic [STAT_W-1:0] loss_q;
  logic [STAT_W-1:0] att_q;
  logic              loss_hit;

  assign loss_hit = (state_q == S_UP) && !start && !link_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      loss_q <= '0;
      att_q  <= '0;
    end else begin
      if (loss_hit)
        loss_q <= sat_inc(loss_q);
      if (start_acc)
        att_q <= '0;
      else if (state_d == S_OOB)
        att_q <= sat_inc(att_q);
    end
  end

  assign link_loss_cnt = loss_q;
  assign attempt_cnt   = att_q;
`else
  assign link_loss_cnt = '0;
  assign attempt_cnt   = '0;
`endif

endmodule

// File: tb/tb_sata_gen_negotiator.sv
// tb_sata_gen_negotiator: self-checking bench with reconfigurator and
// PHY models, vector table, random runs and multi-cycle corner cases.
module tb_sata_gen_negotiator;

  localparam int TIMEOUT = 16;
  localparam int RETRIES = 2;
`ifdef SATA_GEN_NEGOTIATOR_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] max_gen = 2'd0;
  logic       link_up;
  logic       recfg_request;
  logic [1:0] recfg_sata_gen;
  logic       recfg_ready;
  logic       oob_start;
  logic       busy;
  logic       done;
  logic       fail;
  logic [1:0] cur_gen;
  logic [7:0] link_loss_cnt;
  logic [7:0] attempt_cnt;

  sata_gen_negotiator #(
    .TIMEOUT (TIMEOUT),
    .RETRIES (RETRIES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .max_gen        (max_gen),
    .link_up        (link_up),
    .recfg_request  (recfg_request),
    .recfg_sata_gen (recfg_sata_gen),
    .recfg_ready    (recfg_ready),
    .oob_start      (oob_start),
    .busy           (busy),
    .done           (done),
    .fail           (fail),
    .cur_gen        (cur_gen),
    .link_loss_cnt  (link_loss_cnt),
    .attempt_cnt    (attempt_cnt)
  );

  always #5 clk = ~clk;

  // Reconfigurator: ready drops 1 cycle after accept, back 5 later.
  int         rc_cnt;
  logic [1:0] cfg_gen;
  always @(posedge clk) begin
    if (reset) begin
      recfg_ready <= 1'b1;
      rc_cnt      <= 0;
      cfg_gen     <= 2'd0;
    end else if (rc_cnt != 0) begin
      rc_cnt <= (rc_cnt == 6) ? 0 : rc_cnt + 1;
      if (rc_cnt == 1) recfg_ready <= 1'b0;
      if (rc_cnt == 6) recfg_ready <= 1'b1;
    end else if (recfg_request && recfg_ready) begin
      rc_cnt  <= 1;
      cfg_gen <= recfg_sata_gen;
    end
  end

  // PHY: link rises link_dly cycles after OOB if the gen is allowed.
  logic [3:0] ok_mask = 4'd0;
  int         link_dly = 4;
  logic       force_low = 1'b0;
  logic       phy_link;
  int         lcnt;
  assign link_up = phy_link & ~force_low;
  always @(posedge clk) begin
    if (reset || (recfg_request && recfg_ready)) begin
      phy_link <= 1'b0;
      lcnt     <= 0;
    end else if (oob_start) begin
      phy_link <= 1'b0;
      lcnt     <= ok_mask[cfg_gen] ? link_dly : 0;
    end else if (lcnt != 0) begin
      lcnt <= lcnt - 1;
      if (lcnt == 1) phy_link <= 1'b1;
    end
  end

  // Monitor: log accepted generations and OOB pulses.
  logic [1:0] req_log[$];
  int         oob_total = 0;
  always @(posedge clk) begin
    if (!reset) begin
      if (recfg_request && recfg_ready)
        req_log.push_back(recfg_sata_gen);
      if (oob_start) oob_total <= oob_total + 1;
    end
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    check({name, " recfg_request"}, 32'(recfg_request), 0);
    check({name, " recfg_sata_gen"}, 32'(recfg_sata_gen), 0);
    check({name, " oob_start"}, 32'(oob_start), 0);
    check({name, " busy"}, 32'(busy), 0);
    check({name, " done"}, 32'(done), 0);
    check({name, " fail"}, 32'(fail), 0);
    check({name, " cur_gen"}, 32'(cur_gen), 0);
    check({name, " link_loss_cnt"}, 32'(link_loss_cnt), 0);
    check({name, " attempt_cnt"}, 32'(attempt_cnt), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    start     = 1'b0;
    force_low = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] g);
    @(negedge clk);
    max_gen = g;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int base_r;
  int base_o;

  task automatic arm(input logic [3:0] mask, input int dly);
    ok_mask  = mask;
    link_dly = dly;
    base_r   = req_log.size();
    base_o   = oob_total;
  endtask

  task automatic finish_vec(input string name,
                            input int e_nreq,
                            input logic [5:0] e_reqs,
                            input int e_oob,
                            input bit e_done,
                            input logic [1:0] e_cur);
    int         n;
    logic [5:0] got;
    n = 0;
    while (!(done || fail) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!(done || fail))
      check({name, " end_timeout"}, 0, 1);
    got = '0;
    for (int i = base_r; i < req_log.size(); i++)
      if (i - base_r < 3) got[2*(i-base_r) +: 2] = req_log[i];
    check({name, " nreq"}, req_log.size() - base_r, e_nreq);
    check({name, " reqs"}, 32'(got), 32'(e_reqs));
    check({name, " oob"}, oob_total - base_o, e_oob);
    check({name, " done"}, 32'(done), 32'(e_done));
    check({name, " fail"}, 32'(fail), 32'(!e_done));
    check({name, " busy"}, 32'(busy), 0);
    check({name, " cur_gen"}, 32'(cur_gen), 32'(e_cur));
    check({name, " attempt_cnt"}, 32'(attempt_cnt),
          STAT ? e_oob : 0);
  endtask

  task automatic run_vec(input string name, input logic [1:0] g,
                         input logic [3:0] mask, input int dly,
                         input int e_nreq, input logic [5:0] e_reqs,
                         input int e_oob, input bit e_done,
                         input logic [1:0] e_cur);
    arm(mask, dly);
    pulse_start(g);
    finish_vec(name, e_nreq, e_reqs, e_oob, e_done, e_cur);
  endtask

  // Reference: walk generations downward from the clamped max.
  task automatic model(input logic [1:0] g, input logic [3:0] mask,
                       output int nreq, output logic [5:0] reqs,
                       output int noob, output bit dn,
                       output logic [1:0] cur);
    int g0;
    g0   = (g == 2'd0) ? 1 : int'(g);
    nreq = 0;
    reqs = '0;
    noob = 0;
    dn   = 1'b0;
    cur  = 2'd0;
    for (int k = g0; k >= 1; k--) begin
      reqs[2*nreq +: 2] = 2'(k);
      nreq++;
      cur = 2'(k);
      if (mask[k]) begin
        noob++;
        dn = 1'b1;
        break;
      end
      noob += RETRIES;
    end
  endtask

  typedef struct {
    logic [1:0] g;
    logic [3:0] mask;
    int         dly;
    int         nreq;
    logic [5:0] reqs;
    int         oob;
    bit         dn;
    logic [1:0] cur;
  } vec_t;

  vec_t       vecs[6];
  int         m_nreq, m_oob, n, bad;
  logic [5:0] m_reqs;
  bit         m_dn;
  logic [1:0] m_cur, r_g;
  logic [3:0] r_mask;

  initial begin
    vecs[0] = '{2'd3, 4'b1000, 4, 1, 6'h03, 1, 1'b1, 2'd3};
    vecs[1] = '{2'd3, 4'b0010, 4, 3, 6'h1B, 5, 1'b1, 2'd1};
    vecs[2] = '{2'd2, 4'b0000, 4, 2, 6'h06, 4, 1'b0, 2'd1};
    vecs[3] = '{2'd0, 4'b0010, 3, 1, 6'h01, 1, 1'b1, 2'd1};
    vecs[4] = '{2'd1, 4'b0000, 2, 1, 6'h01, 2, 1'b0, 2'd1};
    vecs[5] = '{2'd3, 4'b0100, 6, 2, 6'h0B, 3, 1'b1, 2'd2};

    do_reset();
    chk_idle("reset");

    for (int v = 0; v < 6; v++) begin
      do_reset();
      run_vec($sformatf("vec%0d", v), vecs[v].g, vecs[v].mask,
              vecs[v].dly, vecs[v].nreq, vecs[v].reqs,
              vecs[v].oob, vecs[v].dn, vecs[v].cur);
    end

    // FAIL, then a new start restarts from gen 2.
    do_reset();
    run_vec("fail2", 2'd2, 4'b0000, 4, 2, 6'h06, 4, 1'b0, 2'd1);
    run_vec("restart2", 2'd2, 4'b0000, 4, 2, 6'h06, 4, 1'b0, 2'd1);

    // Link at the exact timeout cycle wins.
    do_reset();
    run_vec("tmo_link", 2'd1, 4'b0010, 13, 1, 6'h01, 1, 1'b1,
            2'd1);

    // start during LINK_WAIT is ignored.
    do_reset();
    arm(4'b0010, 4);
    pulse_start(2'd2);
    n = 0;
    while (!oob_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("lw oob_seen", 32'(oob_start), 1);
    repeat (2) @(negedge clk);
    max_gen = 2'd3;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_vec("lw_ignore", 2, 6'h06, 3, 1'b1, 2'd1);

    // Reset while waiting for reconfiguration to finish.
    do_reset();
    arm(4'b1000, 4);
    pulse_start(2'd3);
    n = 0;
    while (recfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid ready_low", 32'(recfg_ready), 0);
    @(negedge clk);
    check("rst_mid busy_before", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("rst_mid");
    reset = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (recfg_request || busy || oob_start) bad++;
    end
    check("rst_mid stays_idle", bad, 0);

    // Random runs against the reference, no reset in between.
    do_reset();
    for (int r = 0; r < 24; r++) begin
      r_g    = 2'($urandom_range(0, 3));
      r_mask = 4'($urandom_range(0, 15)) & 4'b1110;
      model(r_g, r_mask, m_nreq, m_reqs, m_oob, m_dn, m_cur);
      run_vec($sformatf("rnd%0d", r), r_g, r_mask,
              $urandom_range(1, 10), m_nreq, m_reqs, m_oob,
              m_dn, m_cur);
    end

    // Link loss: re-request at gen_max, counters saturate.
    do_reset();
    run_vec("pre_loss", 2'd3, 4'b0100, 4, 2, 6'h0B, 3, 1'b1, 2'd2);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      force_low = 1'b1;
      n = 0;
      while (!recfg_request && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!recfg_request || recfg_sata_gen != 2'd3) bad++;
      force_low = 1'b0;
      n = 0;
      while (!done && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (!done || cur_gen != 2'd2) bad++;
      if (i == 0)
        check("loss_cnt_1", 32'(link_loss_cnt), STAT ? 1 : 0);
    end
    check("loss_rerequest", bad, 0);
    check("loss_cnt_sat", 32'(link_loss_cnt), STAT ? 255 : 0);
    check("attempt_cnt_sat", 32'(attempt_cnt), STAT ? 255 : 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
